irq_ctrl: RTL and testbench

//  Interrupt source end of the core's int/int_num/nmi inputs. Collects NUM_SRC external

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_sync_edge.sv | 48 ++++
 rtl/irq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
//   Shared definitions for the interrupt controller:
//   - irq_state_t : request FSM states (IDLE=0, ASSERT=1, SERVICE=2)
//   - ADDR_*      : config port register addresses
//   - STATUS_*    : field positions inside the STATUS register
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   localparam logic [1:0] ADDR_ENABLE   = 2'd0;
   localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
   localparam logic [1:0] ADDR_PENDING  = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   // STATUS = {22'b0, state[1:0] at [9:8], 3'b0.., int_num at [ID_W-1:0]}
   localparam int STATUS_STATE_LSB = 8;
   localparam int STATUS_ID_LSB    = 0;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge
//   One interrupt source: 2-flop synchroniser, rising-edge detect and the
//   pending bit.
//   Ports:
//     clk      in  clock
//     rst      in  asynchronous active-low reset
//     src      in  raw asynchronous interrupt line
//     edge_sel in  1 = edge mode (latched), 0 = level mode (follows line)
//     clr      in  clear request (ack of this id or W1C); edge mode only
//     pending  out pending bit
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic src,
   input  logic edge_sel,
   input  logic clr,
   output logic pending
);

   logic sync1;
   logic sync2;
   logic sync_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
         pending   <= 1'b0;
      end else begin
         sync1     <= src;
         sync2     <= sync1;
         sync_prev <= sync2;
         if (edge_sel) begin
            // A new edge beats a simultaneous clear so no event is lost.
            if (sync2 && !sync_prev) begin
               pending <= 1'b1;
            end else if (clr) begin
               pending <= 1'b0;
            end
         end else begin
            // Level mode: the line itself is the pending state.
            pending <= sync2;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
//   Interrupt source for the core: synchronises NUM_SRC lines, latches pending,
//   selects the lowest enabled pending index and holds the request until the
//   core acks; no new request until the core signals complete.
//   Optional feature macro: IRQC_NMI_EN (adds nmi_src_i and the nmi pulse path).
//   Ports:
//     clk_i      in  clock
//     rst        in  asynchronous active-low reset
//     src_i      in  raw interrupt lines [NUM_SRC]
//     nmi_src_i  in  raw NMI line (IRQC_NMI_EN only)
//     cfg_we     in  config write strobe
//     cfg_addr   in  0=ENABLE 1=EDGE_SEL 2=PENDING(W1C) 3=STATUS(RO)
//     cfg_wdata  in  write data
//     cfg_rdata  out combinational read data, zero-extended
//     int_ack_i  in  core accepted the request
//     complete_i in  core finished the handler
//     int_req    out interrupt request ("int" is a reserved word in SystemVerilog)
//     int_num    out requested source id
//     nmi        out one-cycle non-maskable request pulse (0 without IRQC_NMI_EN)
//   Handshake: int_req rises with int_num valid and both stay frozen until the
//   cycle int_ack_i is sampled high; complete_i is honoured only in SERVICE.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk_i,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
`ifdef IRQC_NMI_EN
   input  logic               nmi_src_i,
`endif
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata,
   input  logic               int_ack_i,
   input  logic               complete_i,
   output logic               int_req,
   output logic [ID_W-1:0]    int_num,
   output logic               nmi
);

   irq_state_t         state, state_next;
   logic               int_next;
   logic [ID_W-1:0]    num_next;
   logic [ID_W-1:0]    winner;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] edge_sel;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;

   generate
      if (NUM_SRC < 32) begin : g_wdata_tail
         logic unused_wdata;
         assign unused_wdata = ^cfg_wdata[31:NUM_SRC];
      end
   endgenerate

   // Config registers
   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         enable   <= '0;
         edge_sel <= '0;
      end else if (cfg_we) begin
         if (cfg_addr == ADDR_ENABLE)   enable   <= cfg_wdata[NUM_SRC-1:0];
         if (cfg_addr == ADDR_EDGE_SEL) edge_sel <= cfg_wdata[NUM_SRC-1:0];
      end
   end

   assign w1c     = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[NUM_SRC-1:0] : '0;
   assign ack_clr = (state == ST_ASSERT && int_ack_i) ? (NUM_SRC'(1) << int_num) : '0;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         irq_sync_edge u_src (
            .clk      (clk_i),
            .rst      (rst),
            .src      (src_i[g]),
            .edge_sel (edge_sel[g]),
            .clr      (w1c[g] | ack_clr[g]),
            .pending  (pending[g])
         );
      end
   endgenerate

   assign eligible = pending & enable;

   // Fixed priority: scanning downward leaves the lowest set index.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   // Request FSM, registered outputs
   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         int_req <= 1'b0;
         int_num <= '0;
      end else begin
         state   <= state_next;
         int_req <= int_next;
         int_num <= num_next;
      end
   end

   always_comb begin
      state_next = state;
      int_next   = int_req;
      num_next   = int_num;
      case (state)
         ST_IDLE: begin
            if (|eligible) begin
               state_next = ST_ASSERT;
               int_next   = 1'b1;
               num_next   = winner;
            end
         end
         ST_ASSERT: begin
            if (int_ack_i) begin
               state_next = ST_SERVICE;
               int_next   = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (complete_i) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            int_next   = 1'b0;
         end
      endcase
   end

   // Config read
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_ENABLE:   cfg_rdata[NUM_SRC-1:0] = enable;
         ADDR_EDGE_SEL: cfg_rdata[NUM_SRC-1:0] = edge_sel;
         ADDR_PENDING:  cfg_rdata[NUM_SRC-1:0] = pending;
         ADDR_STATUS: begin
            cfg_rdata[STATUS_STATE_LSB +: 2]  = state;
            cfg_rdata[STATUS_ID_LSB +: ID_W]  = int_num;
         end
         default: cfg_rdata = '0;
      endcase
   end

`ifdef IRQC_NMI_EN
   // Sync (2 flops) + edge detect + output flop: pulse lands 3 cycles after
   // the sampling edge, matching the maskable path's latency.
   logic nmi_s1, nmi_s2, nmi_s3, nmi_rise;

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         nmi_s1   <= 1'b0;
         nmi_s2   <= 1'b0;
         nmi_s3   <= 1'b0;
         nmi_rise <= 1'b0;
         nmi      <= 1'b0;
      end else begin
         nmi_s1   <= nmi_src_i;
         nmi_s2   <= nmi_s1;
         nmi_s3   <= nmi_s2;
         nmi_rise <= nmi_s2 & ~nmi_s3;
         nmi      <= nmi_rise;
      end
   end
`else
   assign nmi = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
//   Directed bench for irq_ctrl (NUM_SRC=8): reset values, latency, priority,
//   level re-request, request freezing, set-beats-clear, async reset and NMI.
module tb_irq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst;
   logic [7:0]  src_i;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        int_ack_i;
   logic        complete_i;
   logic        int_req;
   logic [2:0]  int_num;
   logic        nmi;
`ifdef IRQC_NMI_EN
   logic        nmi_src_i;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   irq_ctrl #(.NUM_SRC(8)) dut (
      .clk_i      (clk_i),
      .rst        (rst),
      .src_i      (src_i),
`ifdef IRQC_NMI_EN
      .nmi_src_i  (nmi_src_i),
`endif
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .int_ack_i  (int_ack_i),
      .complete_i (complete_i),
      .int_req    (int_req),
      .int_num    (int_num),
      .nmi        (nmi)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step(1);
      cfg_we    = 1'b0;
      cfg_wdata = '0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      check(tag, cfg_rdata, exp);
   endtask

   task automatic do_ack();
      int_ack_i = 1'b1;
      step(1);
      int_ack_i = 1'b0;
   endtask

   task automatic do_complete();
      complete_i = 1'b1;
      step(1);
      complete_i = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      src_i      = '0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_wdata  = '0;
      int_ack_i  = 1'b0;
      complete_i = 1'b0;
`ifdef IRQC_NMI_EN
      nmi_src_i  = 1'b0;
`endif
      // Reset state
      step(2);
      check("rst_int", 32'(int_req), 32'd0);
      check("rst_num", 32'(int_num), 32'd0);
      check("rst_nmi", 32'(nmi), 32'd0);
      rd("rst_enable", 2'd0, 32'h0);
      rd("rst_edge", 2'd1, 32'h0);
      rd("rst_pend", 2'd2, 32'h0);
      rd("rst_status", 2'd3, 32'h0);
      rst = 1'b1;
      step(2);

      // 1: single edge source, latency and ack clearing pending
      wr(2'd0, 32'h01);
      wr(2'd1, 32'h01);
      src_i = 8'h01; step(1); src_i = 8'h00; step(2);
      check("t1_int_early", 32'(int_req), 32'd0);
      step(1);
      check("t1_int", 32'(int_req), 32'd1);
      check("t1_num", 32'(int_num), 32'd0);
      rd("t1_status", 2'd3, 32'h100);
      rd("t1_pend", 2'd2, 32'h01);
      step(3);
      check("t1_hold", 32'(int_req), 32'd1);
      do_ack();
      check("t1_ack_int", 32'(int_req), 32'd0);
      rd("t1_pend_ack", 2'd2, 32'h0);
      rd("t1_status_svc", 2'd3, 32'h200);
      do_complete();
      rd("t1_status_idle", 2'd3, 32'h000);

      // 2: simultaneous edges on 5 and 2, lowest index first
      wr(2'd0, 32'hFF);
      wr(2'd1, 32'hFF);
      src_i = 8'h24; step(1); src_i = 8'h00; step(3);
      check("t2_int", 32'(int_req), 32'd1);
      check("t2_num", 32'(int_num), 32'd2);
      rd("t2_pend", 2'd2, 32'h24);
      do_ack();
      rd("t2_pend_ack", 2'd2, 32'h20);
      do_complete();
      check("t2_idle_int", 32'(int_req), 32'd0);
      step(1);
      check("t2_int2", 32'(int_req), 32'd1);
      check("t2_num2", 32'(int_num), 32'd5);
      do_ack();
      do_complete();
      rd("t2_status", 2'd3, 32'h005);
      rd("t2_pend_end", 2'd2, 32'h0);

      // 3: level source held high re-requests after complete
      wr(2'd1, 32'h00);
      src_i = 8'h08; step(4);
      check("t3_int", 32'(int_req), 32'd1);
      check("t3_num", 32'(int_num), 32'd3);
      do_ack();
      check("t3_ack_int", 32'(int_req), 32'd0);
      rd("t3_pend_level", 2'd2, 32'h08);
      do_complete();
      check("t3_idle_int", 32'(int_req), 32'd0);
      step(1);
      check("t3_rereq", 32'(int_req), 32'd1);
      check("t3_rereq_num", 32'(int_num), 32'd3);
      int_ack_i = 1'b1; src_i = 8'h00; step(1); int_ack_i = 1'b0;
      step(3);
      rd("t3_status_svc", 2'd3, 32'h203);
      do_complete();
      step(3);
      check("t3_no_req", 32'(int_req), 32'd0);
      rd("t3_status_idle", 2'd3, 32'h003);
      rd("t3_pend", 2'd2, 32'h0);

      // 4: request frozen in ASSERT; stray ack/complete ignored
      wr(2'd1, 32'h02);
      do_ack();
      rd("t4_ack_in_idle", 2'd3, 32'h003);
      src_i = 8'h02; step(1); src_i = 8'h00; step(3);
      check("t4_int", 32'(int_req), 32'd1);
      check("t4_num", 32'(int_num), 32'd1);
      do_complete();
      rd("t4_cpl_in_assert", 2'd3, 32'h101);
      wr(2'd0, 32'h00);
      check("t4_dis_int", 32'(int_req), 32'd1);
      check("t4_dis_num", 32'(int_num), 32'd1);
      step(2);
      check("t4_dis_hold", 32'(int_req), 32'd1);
      do_ack();
      check("t4_ack_int", 32'(int_req), 32'd0);
      rd("t4_status_svc", 2'd3, 32'h201);
      rd("t4_pend", 2'd2, 32'h0);
      do_complete();
      rd("t4_status_idle", 2'd3, 32'h001);

      // 5: new edge and W1C in the same cycle -> set wins
      wr(2'd1, 32'h10);
      src_i = 8'h10; step(1); src_i = 8'h00; step(1);
      wr(2'd2, 32'h10);
      rd("t5_set_wins", 2'd2, 32'h10);
      check("t5_masked", 32'(int_req), 32'd0);
      wr(2'd2, 32'h10);
      rd("t5_w1c", 2'd2, 32'h0);

      // 6: NMI during SERVICE, then async reset mid-ASSERT
      wr(2'd0, 32'h01);
      wr(2'd1, 32'h01);
      src_i = 8'h01; step(1); src_i = 8'h00; step(3);
      check("t6_int", 32'(int_req), 32'd1);
      do_ack();
      rd("t6_status_svc", 2'd3, 32'h200);
`ifdef IRQC_NMI_EN
      nmi_src_i = 1'b1; step(1); nmi_src_i = 1'b0; step(2);
      check("t6_nmi_early", 32'(nmi), 32'd0);
      step(1);
      check("t6_nmi_pulse", 32'(nmi), 32'd1);
      step(1);
      check("t6_nmi_end", 32'(nmi), 32'd0);
`else
      step(5);
      check("t6_nmi_tied", 32'(nmi), 32'd0);
`endif
      check("t6_svc_int", 32'(int_req), 32'd0);
      rd("t6_status_svc2", 2'd3, 32'h200);
      do_complete();
      src_i = 8'h01; step(1); src_i = 8'h00; step(3);
      check("t6_int2", 32'(int_req), 32'd1);
      rst = 1'b0;
      #1;
      check("t6_rst_int", 32'(int_req), 32'd0);
      check("t6_rst_num", 32'(int_num), 32'd0);
      rd("t6_rst_status", 2'd3, 32'h0);
      rd("t6_rst_enable", 2'd0, 32'h0);
      rd("t6_rst_edge", 2'd1, 32'h0);
      rd("t6_rst_pend", 2'd2, 32'h0);
      rst = 1'b1;
      step(2);
      check("t6_post_int", 32'(int_req), 32'd0);
      rd("t6_post_status", 2'd3, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
